bidirectional_shift_register: RTL and testbench



---
 rtl/bidirectional_shift_register.sv | 56 +++++
 tb/tb_bidirectional_shift_register.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bidirectional_shift_register.sv
// ---------------------------------------------------------------------------
// bidirectional_shift_register
//
// Serial-in, parallel-out shift register whose shift direction is chosen on
// every clock. Used on serial-to-parallel paths where the bit order of the
// incoming stream is only known at run time.
//
// Ports:
//   clk  - sole clock, all state changes on its rising edge
//   clr  - synchronous active-low clear; wins over every other input
//   en   - shift enable, active-high; when low the register holds
//   dir  - 0: shift toward MSB, in enters bit 0
//          1: shift toward LSB, in enters bit WIDTH-1
//   in   - serial data bit
//   out  - parallel register contents, driven straight from the flops
// ---------------------------------------------------------------------------
module bidirectional_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] next_s;

  // Next-state selection: clear beats enable, enable beats hold.
  // X/Z on in is deliberately passed through unchanged.
  always_comb begin
    next_s = shift_r;
    if (clr == 1'b0) begin
      next_s = {WIDTH{1'b0}};
    end else if (en == 1'b1) begin
      case (dir)
        1'b0:    next_s = {shift_r[WIDTH-2:0], in};
        1'b1:    next_s = {in, shift_r[WIDTH-1:1]};
        default: next_s = {WIDTH{1'bx}};
      endcase
    end else begin
      next_s = shift_r;
    end
  end

  // Register update; clear is folded into next_s so it is sampled on the edge.
  always_ff @(posedge clk) begin
    shift_r <= next_s;
  end

  // The output is the register itself, so there is no input-to-output path.
  assign out = shift_r;

endmodule

// File: tb/tb_bidirectional_shift_register.sv
// ---------------------------------------------------------------------------
// Testbench for bidirectional_shift_register (WIDTH = 4).
// Directed steps from the test plan followed by randomized edges, all checked
// against an arithmetic reference: a left shift is value*2+in modulo 16, a
// right shift is value/2 + in*8, clear gives 0 and a disabled edge holds.
// ---------------------------------------------------------------------------
module tb_bidirectional_shift_register;

  localparam int W = 4;
  localparam int MOD = 16;

  logic         clk;
  logic         clr;
  logic         en;
  logic         dir;
  logic         in;
  logic [W-1:0] out;

  int tests;
  int failed;
  int model;
  logic [W-1:0] prev;

  bidirectional_shift_register #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .en  (en),
    .dir (dir),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] exp);
    tests++;
    assert (out === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, out, exp);
    end
  endtask

  // Apply one clock edge with the given inputs, advance the model, check it.
  task automatic do_edge(input logic c, input logic e, input logic d, input logic i);
    @(negedge clk);
    clr = c;
    en  = e;
    dir = d;
    in  = i;
    @(posedge clk);
    if (!c)
      model = 0;
    else if (e) begin
      if (d)
        model = model / 2 + int'(i) * (MOD / 2);
      else
        model = (model * 2 + int'(i)) % MOD;
    end
    #1;
    check("model", W'(model));
  endtask

  // Clear, then shift 1,1,0,1 in from the LSB end.
  task automatic reset_and_fill_1101();
    do_edge(1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b1, 1'b1, 1'b0, 1'b1);
    do_edge(1'b1, 1'b1, 1'b0, 1'b1);
    do_edge(1'b1, 1'b1, 1'b0, 1'b0);
    do_edge(1'b1, 1'b1, 1'b0, 1'b1);
    check("refill", 4'b1101);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    model  = 0;
    clr = 1'b1;
    en  = 1'b0;
    dir = 1'b0;
    in  = 1'b0;

    // Reset with en=1, in=1: clear must win.
    do_edge(1'b0, 1'b1, 1'b0, 1'b1);
    check("reset", 4'b0000);

    // Left fill 1,1,0,1 then in=0 discards the MSB.
    do_edge(1'b1, 1'b1, 1'b0, 1'b1); check("fill1", 4'b0001);
    do_edge(1'b1, 1'b1, 1'b0, 1'b1); check("fill2", 4'b0011);
    do_edge(1'b1, 1'b1, 1'b0, 1'b0); check("fill3", 4'b0110);
    do_edge(1'b1, 1'b1, 1'b0, 1'b1); check("fill4", 4'b1101);
    do_edge(1'b1, 1'b1, 1'b0, 1'b0); check("fill5_msb_drop", 4'b1010);

    // Right shifts from 1101, then an immediate direction change.
    reset_and_fill_1101();
    do_edge(1'b1, 1'b1, 1'b1, 1'b0); check("right1", 4'b0110);
    do_edge(1'b1, 1'b1, 1'b1, 1'b1); check("right2", 4'b1011);
    do_edge(1'b1, 1'b1, 1'b0, 1'b1); check("dir_change", 4'b0111);

    // Rebuild 1011 and hold for three edges while in/dir toggle.
    reset_and_fill_1101();
    do_edge(1'b1, 1'b1, 1'b1, 1'b0);
    do_edge(1'b1, 1'b1, 1'b1, 1'b1);
    check("pre_hold", 4'b1011);
    do_edge(1'b1, 1'b0, 1'b1, 1'b0); check("hold1", 4'b1011);
    do_edge(1'b1, 1'b0, 1'b0, 1'b1); check("hold2", 4'b1011);
    do_edge(1'b1, 1'b0, 1'b1, 1'b0); check("hold3", 4'b1011);
    do_edge(1'b1, 1'b1, 1'b1, 1'b0); check("resume", 4'b0101);

    // Clear mid-stream with en=1, then shifting resumes at once.
    do_edge(1'b0, 1'b1, 1'b0, 1'b1); check("mid_reset", 4'b0000);
    do_edge(1'b1, 1'b1, 1'b0, 1'b1); check("post_reset", 4'b0001);

    // Toggle stream: seven edges left from zero, seven edges right.
    do_edge(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      do_edge(1'b1, 1'b1, 1'b0, (k % 2 == 0) ? 1'b1 : 1'b0);
      if (k == 3) check("toggle_left4", 4'b1010);
    end
    check("toggle_left7", 4'b0101);
    for (int k = 7; k < 14; k++) begin
      logic b;
      b = (k % 2 == 0) ? 1'b1 : 1'b0;
      prev = out;
      do_edge(1'b1, 1'b1, 1'b1, b);
      check("toggle_right", {b, prev[3:1]});
    end

    // Randomized edges with occasional clears.
    for (int k = 0; k < 400; k++) begin
      do_edge(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
